// File: rtl/regfile_port_arbiter.sv
// Four-requester arbiter for one shared register-file read port.
// Round-robin grant with optional bounded lock; read data is registered one cycle after the grant.
module regfile_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          REQ,
  input  logic [3:0]          LOCK,
  input  logic [4*ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0]   RD_DATA,
  output logic [ADDR_W-1:0]   RD_ADDR,
  output logic [3:0]          GNT,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                VALID,
  output logic [1:0]          VALID_ID
);

  // state  | meaning
  // IDLE   | plain round-robin from LAST+1
  // LOCKED | LAST keeps the port while it still requests
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [1:0]          vid_q, vid_d;

  logic [1:0]          win;
  logic [1:0]          idx;
  logic                any_gnt;
  logic                hold;

  // Winner selection: the lock holder keeps the port only while it still requests.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    hold    = (state_q == LOCKED) && REQ[last_q];
    if (hold) begin
      win     = last_q;
      any_gnt = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = last_q + 2'(k);
        if (!any_gnt && REQ[idx]) begin
          win     = idx;
          any_gnt = 1'b1;
        end
      end
    end
    if (reset) begin
      any_gnt = 1'b0;
    end
  end

  always_comb begin
    GNT     = '0;
    RD_ADDR = '0;
    if (any_gnt) begin
      GNT     = 4'b0001 << win;
      RD_ADDR = ADDR[win*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    vid_d   = vid_q;
    if (any_gnt) begin
      data_d  = RD_DATA;
      valid_d = 1'b1;
      vid_d   = win;
      last_d  = win;
      cnt_d   = hold ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
      // Reaching MAX_LOCK drops back to IDLE so the next cycle rotates.
      if (LOCK[win] && (cnt_d < CNT_W'(MAX_LOCK))) begin
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      vid_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      vid_q   <= vid_d;
    end
  end

  assign DATA_OUT = data_q;
  assign VALID    = valid_q;
  assign VALID_ID = vid_q;

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(GNT));

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: round-robin order, lock bound, lock drop,
// reset priority and idle hold, each with hand-computed expectations.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  REQ;
  logic [3:0]  LOCK;
  logic [19:0] ADDR;
  logic [31:0] RD_DATA;
  logic [4:0]  RD_ADDR;
  logic [3:0]  GNT;
  logic [31:0] DATA_OUT;
  logic        VALID;
  logic [1:0]  VALID_ID;

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset), .REQ(REQ), .LOCK(LOCK), .ADDR(ADDR),
    .RD_DATA(RD_DATA), .RD_ADDR(RD_ADDR), .GNT(GNT), .DATA_OUT(DATA_OUT),
    .VALID(VALID), .VALID_ID(VALID_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    REQ = '0;
    LOCK = '0;
    edge_step();
    edge_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    REQ = 4'b1111;
    LOCK = '0;
    RD_DATA = 32'h1111_2222;
    #1;
    checks++;
    if (GNT !== 4'b0000 || RD_ADDR !== 5'd0) begin
      errors++;
      $display("FAIL reset_comb GNT=%b RD_ADDR=%0d expected 0000/0", GNT, RD_ADDR);
    end
    edge_step();
    checks++;
    if (VALID !== 1'b0 || DATA_OUT !== 32'h0 || VALID_ID !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs VALID=%b DATA_OUT=%h VALID_ID=%0d expected 0/0/0", VALID, DATA_OUT, VALID_ID);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    REQ = 4'b1111;
    LOCK = '0;
    for (int i = 0; i < 8; i++) begin
      RD_DATA = 32'h100 + 32'(i);
      #1;
      exp_gnt = 4'b0001 << (i % 4);
      checks++;
      if (GNT !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt[%0d] GNT=%b expected %b", i, GNT, exp_gnt);
      end
      edge_step();
      checks++;
      if (VALID !== 1'b1 || VALID_ID !== 2'(i % 4) || DATA_OUT !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL rr_vid[%0d] VALID=%b VALID_ID=%0d DATA_OUT=%h expected 1/%0d/%h",
                 i, VALID, VALID_ID, DATA_OUT, i % 4, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_single_read();
    REQ = 4'b0100;
    LOCK = '0;
    ADDR = '0;
    ADDR[10 +: 5] = 5'd9;
    ADDR[0 +: 5] = 5'd3;
    RD_DATA = 32'hDEADBEEF;
    #1;
    checks++;
    if (RD_ADDR !== 5'd9 || GNT !== 4'b0100) begin
      errors++;
      $display("FAIL single_comb RD_ADDR=%0d GNT=%b expected 9/0100", RD_ADDR, GNT);
    end
    edge_step();
    checks++;
    if (DATA_OUT !== 32'hDEADBEEF || VALID !== 1'b1 || VALID_ID !== 2'd2) begin
      errors++;
      $display("FAIL single_reg DATA_OUT=%h VALID=%b VALID_ID=%0d expected deadbeef/1/2", DATA_OUT, VALID, VALID_ID);
    end
  endtask

  task automatic test_lock_limit();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    REQ = 4'b0011;
    LOCK = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (GNT !== exp_seq[i]) begin
        errors++;
        $display("FAIL lock_seq[%0d] GNT=%b expected %b", i, GNT, exp_seq[i]);
      end
      edge_step();
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    REQ = 4'b0010;
    LOCK = 4'b0010;
    edge_step();
    edge_step();
    REQ = 4'b1000;
    RD_DATA = 32'h0000_3333;
    #1;
    checks++;
    if (GNT !== 4'b1000) begin
      errors++;
      $display("FAIL drop_gnt GNT=%b expected 1000", GNT);
    end
    edge_step();
    checks++;
    if (VALID_ID !== 2'd3 || DATA_OUT !== 32'h0000_3333) begin
      errors++;
      $display("FAIL drop_vid VALID_ID=%0d DATA_OUT=%h expected 3/00003333", VALID_ID, DATA_OUT);
    end
    // A stale lock on requester 3 would grant it here; IDLE searches from 0 and finds 1.
    REQ = 4'b1010;
    LOCK = 4'b0000;
    #1;
    checks++;
    if (GNT !== 4'b0010) begin
      errors++;
      $display("FAIL drop_idle GNT=%b expected 0010", GNT);
    end
    edge_step();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    REQ = 4'b1111;
    LOCK = 4'b1111;
    RD_DATA = 32'h0000_1234;
    edge_step();
    edge_step();
    checks++;
    if (DATA_OUT !== 32'h0000_1234 || VALID !== 1'b1 || VALID_ID !== 2'd0) begin
      errors++;
      $display("FAIL midlock_pre DATA_OUT=%h VALID=%b VALID_ID=%0d expected 00001234/1/0", DATA_OUT, VALID, VALID_ID);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (GNT !== 4'b0000 || RD_ADDR !== 5'd0) begin
      errors++;
      $display("FAIL midlock_gnt GNT=%b RD_ADDR=%0d expected 0000/0", GNT, RD_ADDR);
    end
    edge_step();
    checks++;
    if (VALID !== 1'b0 || DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL midlock_regs VALID=%b DATA_OUT=%h expected 0/0", VALID, DATA_OUT);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (GNT !== 4'b0001) begin
      errors++;
      $display("FAIL midlock_first GNT=%b expected 0001", GNT);
    end
    edge_step();
  endtask

  task automatic test_idle_hold();
    REQ = 4'b0100;
    LOCK = '0;
    RD_DATA = 32'hCAFEF00D;
    #1;
    checks++;
    if (GNT !== 4'b0100) begin
      errors++;
      $display("FAIL hold_gnt GNT=%b expected 0100", GNT);
    end
    edge_step();
    REQ = '0;
    RD_DATA = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (GNT !== 4'b0000 || RD_ADDR !== 5'd0) begin
        errors++;
        $display("FAIL hold_comb[%0d] GNT=%b RD_ADDR=%0d expected 0000/0", i, GNT, RD_ADDR);
      end
      edge_step();
      checks++;
      if (VALID !== 1'b0 || DATA_OUT !== 32'hCAFEF00D || VALID_ID !== 2'd2) begin
        errors++;
        $display("FAIL hold_regs[%0d] VALID=%b DATA_OUT=%h VALID_ID=%0d expected 0/cafef00d/2",
                 i, VALID, DATA_OUT, VALID_ID);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    REQ = '0;
    LOCK = '0;
    ADDR = {5'd7, 5'd6, 5'd5, 5'd4};
    RD_DATA = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single_read();
    test_lock_limit();
    test_lock_drop();
    test_reset_mid_lock();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: register data width.
REQ-002 The module SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 The module SHALL have parameter MAX_LOCK, default 4: maximum consecutive grants to one requester.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port REQ, input, 4 bits: per-requester read request.
REQ-007 The module SHALL have port LOCK, input, 4 bits: per-requester request to keep the grant on the next cycle.
REQ-008 The module SHALL have port ADDR, input, 4*ADDR_W bits: requester i's address in ADDR[i*ADDR_W +: ADDR_W].
REQ-009 The module SHALL have port RD_DATA, input, DATA_W bits: combinational read data from the shared register-file read port.
REQ-010 The module SHALL have port RD_ADDR, output, ADDR_W bits: address driven to the shared read port.
REQ-011 The module SHALL have port GNT, output, 4 bits: combinational one-hot grant for the current cycle.
REQ-012 The module SHALL have port DATA_OUT, output, DATA_W bits: registered read data.
REQ-013 The module SHALL have port VALID, output, 1 bit: DATA_OUT holds data for the grant issued in the previous cycle.
REQ-014 The module SHALL have port VALID_ID, output, 2 bits: index of the requester that DATA_OUT belongs to.

Function
REQ-015 The module SHALL keep a 2-bit LAST pointer, a state in {IDLE, LOCKED}, and a lock counter sized for 0..MAX_LOCK.
REQ-016 In IDLE with REQ nonzero, GNT SHALL select the first requester with REQ set, searching from LAST+1 upward and wrapping modulo 4.
REQ-017 In LOCKED, GNT SHALL select LAST if REQ[LAST]=1.
REQ-018 In LOCKED with REQ[LAST]=0, the module SHALL arbitrate as in IDLE in that same cycle.
REQ-019 GNT SHALL be all-zero when REQ=0, and at most one GNT bit SHALL be set in any cycle.
REQ-020 RD_ADDR SHALL equal the granted requester's ADDR slice, and SHALL be 0 when there is no grant.
REQ-021 On a clock edge with winner w, DATA_OUT SHALL capture RD_DATA, VALID SHALL become 1, VALID_ID SHALL become w, and LAST SHALL become w (latency 1 cycle).
REQ-022 On a clock edge with no grant, VALID SHALL become 0, while DATA_OUT, VALID_ID and LAST hold their values.
REQ-023 Lock counter: set to 1 when a grant goes to a requester different from the previous holder or is issued from IDLE; increment on each repeated LOCKED grant to the same requester.
REQ-024 Transition IDLE->LOCKED or LOCKED->LOCKED SHALL occur when the winner has LOCK[w]=1 and the post-update count is below MAX_LOCK.
REQ-025 All other cases SHALL go to IDLE, including count reaching MAX_LOCK, which forces rotation on the next cycle.
REQ-026 LOCK bits of non-granted requesters SHALL be ignored.
REQ-027 LOCK[w] with REQ[w]=0 SHALL have no effect.

Reset
REQ-028 While reset=1 at a clock edge, the module SHALL set state IDLE, LAST=3, lock count 0, DATA_OUT=0, VALID=0 and VALID_ID=0.
REQ-029 Reset SHALL take priority over any grant in the same cycle, with no capture.
REQ-030 While reset=1, GNT SHALL be 0 and RD_ADDR SHALL be 0.
REQ-031 The first grant after reset SHALL favour requester 0.

Verification
REQ-032 Reset, then REQ=4'b1111, LOCK=0 for 8 cycles -> GNT sequence 0001,0010,0100,1000,0001,...; VALID_ID lags GNT by one cycle as 0,1,2,3,0.
REQ-033 REQ=4'b0100, ADDR2=5'd9, RD_DATA=32'hDEADBEEF -> RD_ADDR=9 and GNT=0100 the same cycle; next cycle DATA_OUT=DEADBEEF, VALID=1, VALID_ID=2.
REQ-034 REQ=4'b0011, LOCK=4'b0001 held -> requester 0 granted for exactly 4 consecutive cycles, then requester 1 for 1 cycle, then requester 0 again.
REQ-035 Requester 1 locked (count 2) and drops REQ[1] while REQ=4'b1000 -> GNT=1000 in that cycle and state returns to IDLE.
REQ-036 Assert reset mid-lock with REQ=4'b1111 -> next cycle VALID=0 and DATA_OUT=0; first post-reset grant is 0001.
REQ-037 REQ=0 for 3 cycles after a grant -> VALID=0 and GNT=0; DATA_OUT and VALID_ID hold their last values.
